hazard_ctrl_unit: RTL and testbench

- Parametrised stall/flush controller for the 5-stage RV32I forwarding pipeline.
- Generalises the fixed single-cycle load stall into a configurable multi-cycle data-memory wait FSM.
- Adds a register-use qualified load-use check, valid-qualified stage tracking, and saturating hazard performance counters.
- Drives the stall/flush pins of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/hazard_ctrl_unit_if.sv | 60 ++++++
 rtl/hazard_ctrl_unit.sv | 130 +++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_unit_if.sv
// Hazard controller bundle: pipeline-side hazard inputs and stall/flush controls.
// Latency: wires only. Control outputs are combinational from the unit, counters are registered.
// Backpressure: none on the bundle itself; the stall outputs are the backpressure to the pipeline.
// Optional macro HAZ_DMEM_HANDSHAKE_EN adds i_dmem_ready (data memory has completed the access).
// master: the pipeline datapath side. slave: hazard_ctrl_unit.
interface hazard_ctrl_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] i_ID_rs1_addr;
  logic [REG_AW-1:0] i_ID_rs2_addr;
  logic              i_ID_rs1_used;
  logic              i_ID_rs2_used;
  logic              i_EX_valid;
  logic              i_EX_pc_sel;
  logic              i_EX_rd_wren;
  logic [REG_AW-1:0] i_EX_rd_addr;
  logic [31:0]       i_EX_inst;
  logic              i_MEM_valid;
  logic [31:0]       i_MEM_inst;
`ifdef HAZ_DMEM_HANDSHAKE_EN
  logic              i_dmem_ready;
`endif
  logic              o_pc_stall;
  logic              o_IF_ID_stall;
  logic              o_IF_ID_flush;
  logic              o_ID_EX_stall;
  logic              o_ID_EX_flush;
  logic              o_EX_MEM_stall;
  logic              o_EX_MEM_flush;
  logic              o_MEM_WB_stall;
  logic              o_MEM_WB_flush;
  logic              o_mem_busy;
  logic [CNT_W-1:0]  o_perf_stall_cnt;
  logic [CNT_W-1:0]  o_perf_flush_cnt;

  modport master (
    output i_ID_rs1_addr, i_ID_rs2_addr, i_ID_rs1_used, i_ID_rs2_used,
    output i_EX_valid, i_EX_pc_sel, i_EX_rd_wren, i_EX_rd_addr, i_EX_inst,
    output i_MEM_valid, i_MEM_inst,
`ifdef HAZ_DMEM_HANDSHAKE_EN
    output i_dmem_ready,
`endif
    input  o_pc_stall, o_IF_ID_stall, o_IF_ID_flush, o_ID_EX_stall, o_ID_EX_flush,
    input  o_EX_MEM_stall, o_EX_MEM_flush, o_MEM_WB_stall, o_MEM_WB_flush,
    input  o_mem_busy, o_perf_stall_cnt, o_perf_flush_cnt
  );

  modport slave (
    input  i_ID_rs1_addr, i_ID_rs2_addr, i_ID_rs1_used, i_ID_rs2_used,
    input  i_EX_valid, i_EX_pc_sel, i_EX_rd_wren, i_EX_rd_addr, i_EX_inst,
    input  i_MEM_valid, i_MEM_inst,
`ifdef HAZ_DMEM_HANDSHAKE_EN
    input  i_dmem_ready,
`endif
    output o_pc_stall, o_IF_ID_stall, o_IF_ID_flush, o_ID_EX_stall, o_ID_EX_flush,
    output o_EX_MEM_stall, o_EX_MEM_flush, o_MEM_WB_stall, o_MEM_WB_flush,
    output o_mem_busy, o_perf_stall_cnt, o_perf_flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Stall/flush controller for the 5-stage RV32I pipeline: multi-cycle dmem wait, branch flush, load-use bubble.
// Latency: controls are combinational in the cycle the hazard is visible; perf counters update on the next edge.
// Backpressure: a MEM load holds PC..EX/MEM for MEM_LAT cycles (or until i_dmem_ready), bubbling MEM/WB.
// Ports: i_clk, i_reset (sync, active high), bus (hazard_ctrl_unit_if.slave) carrying ID/EX/MEM hazard
// inputs, the nine stage stall/flush controls, o_mem_busy and the two saturating perf counters.
// Optional macro HAZ_DMEM_HANDSHAKE_EN: WAIT additionally requires i_dmem_ready before releasing the load.
module hazard_ctrl_unit #(
  parameter int MEM_LAT = 1,   // 0..15, 0 = ideal memory
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 16
) (
  input logic             i_clk,
  input logic             i_reset,
  hazard_ctrl_unit_if.slave bus
);
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [4:0] LAT5    = 5'(MEM_LAT);
  localparam logic [3:0] LAT_M1  = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RELEASE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [4:0]        cnt_inc;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_load, ex_load, rs_hit, load_use, branch;
  logic              mem_stall, stall_grp, branch_flush, lu_stall, pc_stall;
  logic              dmem_ready;
  logic              unused_inst_bits;

  assign unused_inst_bits = ^{bus.i_EX_inst[31:7], bus.i_MEM_inst[31:7]};

`ifdef HAZ_DMEM_HANDSHAKE_EN
  assign dmem_ready = bus.i_dmem_ready;
`else
  assign dmem_ready = 1'b1;
`endif

  assign mem_load = bus.i_MEM_valid && (bus.i_MEM_inst[6:0] == OP_LOAD);
  assign ex_load  = bus.i_EX_valid  && (bus.i_EX_inst[6:0]  == OP_LOAD);
  assign ex_rd    = bus.i_EX_rd_addr;
  assign rs_hit   = (bus.i_ID_rs1_used && (ex_rd == bus.i_ID_rs1_addr)) ||
                    (bus.i_ID_rs2_used && (ex_rd == bus.i_ID_rs2_addr));
  // Only a load in EX needs a bubble; everything else is covered by forwarding.
  assign load_use = ex_load && bus.i_EX_rd_wren && (ex_rd != '0) && rs_hit;
  assign branch   = bus.i_EX_valid && bus.i_EX_pc_sel;
  assign cnt_inc  = {1'b0, cnt_q} + 5'd1;

  // Data-memory wait sequencer. RELEASE is a one-cycle gap that lets the load
  // leave MEM without being seen again as a fresh load in IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_load && (MEM_LAT != 0)) begin
          mem_stall = 1'b1;
          cnt_d     = 4'd1;
`ifdef HAZ_DMEM_HANDSHAKE_EN
          if ((MEM_LAT == 1) && dmem_ready) state_d = RELEASE;
          else                              state_d = WAIT;
`else
          state_d = (MEM_LAT == 1) ? RELEASE : WAIT;
`endif
        end
      end
      WAIT: begin
        mem_stall = 1'b1;
`ifdef HAZ_DMEM_HANDSHAKE_EN
        // Minimum latency reached: park the counter and wait for memory.
        if (cnt_inc >= LAT5) begin
          cnt_d = LAT_M1;
          if (dmem_ready) state_d = RELEASE;
        end else begin
          cnt_d = cnt_inc[3:0];
        end
`else
        cnt_d = cnt_inc[3:0];
        if (cnt_inc == LAT5) state_d = RELEASE;
`endif
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // One winner per cycle: MEM stall, then branch flush, then load-use.
  // A branch frozen in EX by the MEM stall wins as soon as the stall drops.
  assign stall_grp    = !i_reset && mem_stall;
  assign branch_flush = !i_reset && !mem_stall && branch;
  assign lu_stall     = !i_reset && !mem_stall && !branch && load_use;
  assign pc_stall     = stall_grp || lu_stall;

  assign bus.o_pc_stall     = pc_stall;
  assign bus.o_IF_ID_stall  = pc_stall;
  assign bus.o_IF_ID_flush  = branch_flush;
  assign bus.o_ID_EX_stall  = stall_grp;
  assign bus.o_ID_EX_flush  = branch_flush || lu_stall;
  assign bus.o_EX_MEM_stall = stall_grp;
  assign bus.o_EX_MEM_flush = 1'b0;
  assign bus.o_MEM_WB_stall = 1'b0;
  assign bus.o_MEM_WB_flush = stall_grp;
  assign bus.o_mem_busy     = stall_grp;

  // Saturating performance counters.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_stall && (stall_cnt_q != '1))     stall_cnt_q <= stall_cnt_q + 1'b1;
      if (branch_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.o_perf_stall_cnt = stall_cnt_q;
  assign bus.o_perf_flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
`timescale 1ns/1ps
module tb_hazard_ctrl_unit;
  localparam int NDUT = 6;   // dut d has MEM_LAT=d for d<5; dut5 is MEM_LAT=1, CNT_W=4
`ifdef HAZ_DMEM_HANDSHAKE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif
  localparam logic [6:0] LOAD = 7'b0000011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  rs1, rs2, ex_rd;
  logic        rs1_used, rs2_used, ex_valid, ex_pc_sel, ex_rd_wren, mem_valid, dmem_ready;
  logic [31:0] ex_inst, mem_inst;

  logic [9:0]  outs [NDUT];
  logic [15:0] scnt [NDUT];
  logic [15:0] fcnt [NDUT];
  logic [9:0]  last_outs [NDUT];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: elapsed stall cycles of the current load (-1 = none),
  // a one-cycle "load leaving MEM" flag, and plain cycle counts.
  int m_k [NDUT];
  bit m_rel [NDUT];
  int m_sc [NDUT];
  int m_fc [NDUT];
  int seen_stall [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int LAT = (g == 5) ? 1 : g;
    localparam int CW  = (g == 5) ? 4 : 16;
    hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(CW)) bus ();
    assign bus.i_ID_rs1_addr = rs1;
    assign bus.i_ID_rs2_addr = rs2;
    assign bus.i_ID_rs1_used = rs1_used;
    assign bus.i_ID_rs2_used = rs2_used;
    assign bus.i_EX_valid    = ex_valid;
    assign bus.i_EX_pc_sel   = ex_pc_sel;
    assign bus.i_EX_rd_wren  = ex_rd_wren;
    assign bus.i_EX_rd_addr  = ex_rd;
    assign bus.i_EX_inst     = ex_inst;
    assign bus.i_MEM_valid   = mem_valid;
    assign bus.i_MEM_inst    = mem_inst;
`ifdef HAZ_DMEM_HANDSHAKE_EN
    assign bus.i_dmem_ready  = dmem_ready;
`endif
    hazard_ctrl_unit #(.MEM_LAT(LAT), .REG_AW(5), .CNT_W(CW)) u_dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus.slave)
    );
    assign outs[g] = {bus.o_pc_stall, bus.o_IF_ID_stall, bus.o_IF_ID_flush, bus.o_ID_EX_stall,
                      bus.o_ID_EX_flush, bus.o_EX_MEM_stall, bus.o_EX_MEM_flush, bus.o_MEM_WB_stall,
                      bus.o_MEM_WB_flush, bus.o_mem_busy};
    assign scnt[g] = 16'(bus.o_perf_stall_cnt);
    assign fcnt[g] = 16'(bus.o_perf_flush_cnt);
  end

  function automatic int lat_of(int d);
    return (d == 5) ? 1 : d;
  endfunction

  function automatic int cmax(int d);
    return (d == 5) ? 15 : 65535;
  endfunction

  function automatic logic [31:0] load_inst(logic [4:0] rd);
    return {12'h004, 5'd2, 3'b010, rd, LOAD};
  endfunction

  // One clock: check outputs against the model mid-cycle, then advance the model.
  task automatic cycle(input string tag);
    bit ld, br, lu, rdy;
    bit s [NDUT];
    bit wbr [NDUT];
    logic [9:0] exp;
    #1;
    ld  = mem_valid && (mem_inst[6:0] == LOAD);
    br  = ex_valid && ex_pc_sel;
    lu  = ex_valid && (ex_inst[6:0] == LOAD) && ex_rd_wren && (ex_rd != 5'd0) &&
          ((rs1_used && ex_rd == rs1) || (rs2_used && ex_rd == rs2));
    rdy = dmem_ready || !HS;
    for (int d = 0; d < NDUT; d++) begin
      bit wlu;
      if (rst || m_rel[d])   s[d] = 1'b0;
      else if (m_k[d] >= 0)  s[d] = 1'b1;
      else                   s[d] = ld && (lat_of(d) >= 1);
      wbr[d] = !rst && !s[d] && br;
      wlu    = !rst && !s[d] && !br && lu;
      exp = {s[d] | wlu, s[d] | wlu, wbr[d], s[d], wbr[d] | wlu, s[d], 1'b0, 1'b0, s[d], s[d]};
      last_outs[d] = outs[d];
      if (outs[d][9] === 1'b1) seen_stall[d]++;
      vectors++;
      if (outs[d] !== exp) begin
        miscompares++;
        $display("FAIL %s dut%0d controls got %b want %b", tag, d, outs[d], exp);
      end
      vectors++;
      if (scnt[d] !== 16'(m_sc[d])) begin
        miscompares++;
        $display("FAIL %s dut%0d stall_cnt got %0d want %0d", tag, d, scnt[d], m_sc[d]);
      end
      vectors++;
      if (fcnt[d] !== 16'(m_fc[d])) begin
        miscompares++;
        $display("FAIL %s dut%0d flush_cnt got %0d want %0d", tag, d, fcnt[d], m_fc[d]);
      end
    end
    @(posedge clk);
    for (int d = 0; d < NDUT; d++) begin
      if (rst) begin
        m_k[d] = -1; m_rel[d] = 1'b0; m_sc[d] = 0; m_fc[d] = 0;
      end else begin
        bit wlu;
        wlu = !s[d] && !br && lu;
        if ((s[d] || wlu) && m_sc[d] < cmax(d)) m_sc[d]++;
        if (wbr[d] && m_fc[d] < cmax(d)) m_fc[d]++;
        if (m_rel[d]) m_rel[d] = 1'b0;
        else if (s[d]) begin
          int k;
          k = (m_k[d] >= 0) ? m_k[d] : 0;
          // A load is released after at least MEM_LAT stall cycles and memory ready.
          if (k >= lat_of(d) - 1 && rdy) begin m_k[d] = -1; m_rel[d] = 1'b1; end
          else m_k[d] = k + 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0; ex_valid = 0; ex_pc_sel = 0;
    ex_rd_wren = 0; ex_rd = 0; ex_inst = 32'h13; mem_valid = 0; mem_inst = 32'h13;
    dmem_ready = 1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    cycle("reset");
    rst = 0;
    for (int d = 0; d < NDUT; d++) seen_stall[d] = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    mem_valid = 1; mem_inst = load_inst(5'd5);
    ex_valid = 1; ex_pc_sel = 1;
    repeat (3) cycle("reset_hold");
    for (int d = 0; d < NDUT; d++) begin
      vectors++;
      if (last_outs[d] !== 10'd0 || scnt[d] !== 16'd0) begin
        miscompares++;
        $display("FAIL reset_state dut%0d got %b/%0d want 0/0", d, last_outs[d], scnt[d]);
      end
    end
    rst = 0;
  endtask

  task automatic test_lat1();
    do_reset();
    mem_valid = 1; mem_inst = load_inst(5'd5);
    repeat (2) cycle("lat1_load");
    mem_inst = 32'h00208033;
    repeat (2) cycle("lat1_next");
    vectors++;
    if (seen_stall[1] !== 1 || scnt[1] !== 16'd1) begin
      miscompares++;
      $display("FAIL lat1_stalls got %0d cycles cnt %0d want 1/1", seen_stall[1], scnt[1]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem_valid = 1; mem_inst = load_inst(5'd5);
    repeat (4) cycle("b2b_first");
    mem_inst = load_inst(5'd6);
    repeat (4) cycle("b2b_second");
    mem_valid = 0;
    repeat (2) cycle("b2b_idle");
    vectors++;
    if (seen_stall[3] !== 6 || scnt[3] !== 16'd6) begin
      miscompares++;
      $display("FAIL b2b_lat3 got %0d cycles cnt %0d want 6/6", seen_stall[3], scnt[3]);
    end
  endtask

  task automatic test_load_use();
    logic [9:0] want [3];
    want[0] = 10'b1100100000; want[1] = 10'd0; want[2] = 10'd0;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      ex_valid = 1; ex_rd_wren = 1;
      ex_rd = (c == 2) ? 5'd0 : 5'd7;
      ex_inst = load_inst(ex_rd);
      rs2 = ex_rd; rs2_used = (c != 1); rs1 = 5'd3; rs1_used = 1;
      cycle("load_use");
      vectors++;
      if (last_outs[0] !== want[c]) begin
        miscompares++;
        $display("FAIL load_use case%0d got %b want %b", c, last_outs[0], want[c]);
      end
    end
    clear_inputs();
    cycle("load_use_idle");
  endtask

  task automatic test_priority();
    do_reset();
    mem_valid = 1; mem_inst = load_inst(5'd4);
    ex_valid = 1; ex_pc_sel = 1; ex_inst = 32'h0000_0063;
    for (int c = 0; c < 3; c++) begin
      logic [2:0] got, want;
      cycle("priority");
      got  = {last_outs[2][9], last_outs[2][7], last_outs[2][5]};
      want = (c < 2) ? 3'b100 : 3'b011;
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL priority c%0d stall/ifid_fl/idex_fl got %b want %b", c, got, want);
      end
    end
    clear_inputs();
    cycle("priority_idle");
    vectors++;
    if (fcnt[2] !== 16'd1) begin
      miscompares++;
      $display("FAIL priority_flush_cnt got %0d want 1", fcnt[2]);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    mem_valid = 1; mem_inst = load_inst(5'd8);
    repeat (2) cycle("midwait_pre");
    rst = 1;
    cycle("midwait_rst");
    rst = 0; mem_valid = 0;
    cycle("midwait_after");
    vectors++;
    if (last_outs[4] !== 10'd0 || scnt[4] !== 16'd0 || fcnt[4] !== 16'd0) begin
      miscompares++;
      $display("FAIL midwait_clear got %b/%0d want 0/0", last_outs[4], scnt[4]);
    end
    seen_stall[4] = 0;
    mem_valid = 1;
    repeat (5) cycle("midwait_reload");
    mem_valid = 0;
    cycle("midwait_idle");
    vectors++;
    if (seen_stall[4] !== 4 || scnt[4] !== 16'd4) begin
      miscompares++;
      $display("FAIL midwait_full got %0d cycles cnt %0d want 4/4", seen_stall[4], scnt[4]);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ex_valid = 1; ex_rd_wren = 1; ex_rd = 5'd9; ex_inst = load_inst(5'd9);
    rs1 = 5'd9; rs1_used = 1;
    repeat (20) cycle("saturate");
    clear_inputs();
    cycle("saturate_idle");
    vectors++;
    if (scnt[5] !== 16'd15 || scnt[0] !== 16'd20) begin
      miscompares++;
      $display("FAIL saturation got %0d/%0d want 15/20", scnt[5], scnt[0]);
    end
  endtask

  task automatic test_handshake();
    do_reset();
    mem_valid = 1; mem_inst = load_inst(5'd5); dmem_ready = 0;
    repeat (5) cycle("hs_notready");
    dmem_ready = 1;
    repeat (2) cycle("hs_ready");
    mem_valid = 0;
    cycle("hs_idle");
    vectors++;
    if (seen_stall[2] !== 6 || scnt[2] !== 16'd6) begin
      miscompares++;
      $display("FAIL handshake_lat2 got %0d cycles cnt %0d want 6/6", seen_stall[2], scnt[2]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 63) == 0);
      mem_valid  = $urandom_range(0, 1);
      mem_inst   = ($urandom_range(0, 9) < 6) ? load_inst(5'($urandom_range(0, 31))) : $urandom;
      ex_valid   = $urandom_range(0, 1);
      ex_pc_sel  = ($urandom_range(0, 3) == 0);
      ex_rd_wren = $urandom_range(0, 1);
      ex_rd      = 5'($urandom_range(0, 3));
      ex_inst    = ($urandom_range(0, 1) == 1) ? load_inst(ex_rd) : $urandom;
      rs1        = 5'($urandom_range(0, 3));
      rs2        = 5'($urandom_range(0, 3));
      rs1_used   = $urandom_range(0, 1);
      rs2_used   = $urandom_range(0, 1);
      dmem_ready = ($urandom_range(0, 3) != 0);
      cycle("random");
    end
    rst = 0;
    clear_inputs();
    cycle("random_idle");
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      m_k[d] = -1; m_rel[d] = 1'b0; m_sc[d] = 0; m_fc[d] = 0; seen_stall[d] = 0;
      last_outs[d] = '0;
    end
    clear_inputs();
    rst = 1;
    @(negedge clk);
    test_reset();
    test_lat1();
    test_back_to_back();
    test_load_use();
    test_priority();
    test_reset_mid_wait();
    test_saturation();
`ifdef HAZ_DMEM_HANDSHAKE_EN
    test_handshake();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
